// File: rtl/zsdram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zsdram_rw_arbiter
// Purpose  : N-channel read/write arbiter in front of the single-port SDRAM
//            base controller. Picks one requesting client (fixed priority or
//            round robin), registers its address/data/direction toward the
//            controller, routes done / read data back, and aborts a stalled
//            transaction through a watchdog.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            i_en                  allow new grants
//            i_req/i_ch_we         per-channel request level / direction
//            i_ch_addr/i_ch_wdata  packed per-channel address / write data
//            o_ch_done/o_ch_rdata  completion pulse / read data to clients
//            o_grant/o_busy        one-hot owner / transaction in progress
//            o_timeout_err         watchdog fired (one clock)
//            o_sd_call/o_sd_addr/o_sd_wdata   command to SDRAM controller
//            i_sd_done/i_sd_rdata             response from SDRAM controller
// Revision : 1.0 - initial release
// ============================================================================
module zsdram_rw_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int MODE    = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_wdata,
  output logic [NUM_CH-1:0]        o_ch_done,
  output logic [DATA_W-1:0]        o_ch_rdata,
  output logic [NUM_CH-1:0]        o_grant,
  output logic                     o_busy,
  output logic                     o_timeout_err,
  output logic [1:0]               o_sd_call,
  output logic [ADDR_W-1:0]        o_sd_addr,
  output logic [DATA_W-1:0]        o_sd_wdata,
  input  logic [1:0]               i_sd_done,
  input  logic [DATA_W-1:0]        i_sd_rdata
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit c_WD_EN = (TIMEOUT != 0);
  localparam logic [NUM_CH-1:0] c_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_WAIT    = 2'd1;
  localparam logic [1:0] c_ST_RELEASE = 2'd2;

  logic [1:0]        r_state;
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_wd_cnt;
  logic [NUM_CH-1:0] r_grant;
  logic [NUM_CH-1:0] r_ch_done;
  logic [DATA_W-1:0] r_ch_rdata;
  logic              r_busy;
  logic              r_tmo;
  logic [1:0]        r_sd_call;
  logic [ADDR_W-1:0] r_sd_addr;
  logic [DATA_W-1:0] r_sd_wdata;

  logic [PW-1:0]     w_scan;
  logic [PW-1:0]     w_win_idx;
  logic              w_win_vld;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_we;
  logic              w_match;
  logic              w_wd_fire;

  // Winner scan: in round-robin mode the scan starts at r_ptr and wraps, in
  // fixed-priority mode it starts at index 0. First set request wins.
  always_comb begin
    w_scan    = '0;
    w_win_idx = '0;
    w_win_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (MODE == 0) w_scan = PW'(i);
      else           w_scan = PW'((int'(r_ptr) + i) % NUM_CH);
      if (!w_win_vld && i_req[w_scan]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_win_addr  = i_ch_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
    w_win_wdata = i_ch_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
    w_win_we    = i_ch_we[w_win_idx];
  end

  // Only the done bit matching the registered direction completes the
  // transaction; r_sd_call[1] is the write flag of the owned transaction.
  assign w_match   = r_sd_call[1] ? i_sd_done[1] : i_sd_done[0];
  assign w_wd_fire = c_WD_EN && (r_wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_ptr      <= '0;
      r_wd_cnt   <= '0;
      r_grant    <= '0;
      r_ch_done  <= '0;
      r_ch_rdata <= '0;
      r_busy     <= 1'b0;
      r_tmo      <= 1'b0;
      r_sd_call  <= 2'b00;
      r_sd_addr  <= '0;
      r_sd_wdata <= '0;
    end else begin
      r_ch_done <= '0;
      r_tmo     <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (i_en && w_win_vld) begin
            r_grant    <= c_ONE << w_win_idx;
            r_sd_addr  <= w_win_addr;
            r_sd_wdata <= w_win_wdata;
            r_sd_call  <= w_win_we ? 2'b10 : 2'b01;
            r_busy     <= 1'b1;
            r_wd_cnt   <= '0;
            if (int'(w_win_idx) == NUM_CH - 1) r_ptr <= '0;
            else                               r_ptr <= w_win_idx + 1'b1;
            r_state    <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (w_match || w_wd_fire) begin
            // Done pulse goes to the current owner; rdata only on a real read
            // completion, never on a write or a watchdog abort.
            r_ch_done <= r_grant;
            if (w_match && !r_sd_call[1]) r_ch_rdata <= i_sd_rdata;
            r_tmo     <= !w_match;
            r_sd_call <= 2'b00;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_state   <= c_ST_RELEASE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        c_ST_RELEASE: begin
          // One idle clock so the client can drop req before re-arbitration.
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign o_ch_done     = r_ch_done;
  assign o_ch_rdata    = r_ch_rdata;
  assign o_grant       = r_grant;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_tmo;
  assign o_sd_call     = r_sd_call;
  assign o_sd_addr     = r_sd_addr;
  assign o_sd_wdata    = r_sd_wdata;

endmodule
`default_nettype wire
